// File: rtl/sdpram_pkg.sv
// sdpram_pkg
//   Shared defaults and word/address types for the simple dual-port RAM
//   and its bundling interface.
package sdpram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

endpackage : sdpram_pkg

// File: rtl/sdpram_if.sv
// sdpram_if
//   Bundles the data-path signals of a simple dual-port RAM.
//   Port A is write-only, port B is read-only with registered output.
//   Modports:
//     ram  : wena/addra/dina/renb/addrb in, doutb/doutb_valid out
//     user : directions reversed
interface sdpram_if
  import sdpram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                  wena;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic                  renb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  doutb_valid;

  modport ram (
    input  wena, addra, dina, renb, addrb,
    output doutb, doutb_valid
  );

  modport user (
    output wena, addra, dina, renb, addrb,
    input  doutb, doutb_valid
  );

endinterface : sdpram_if

// File: rtl/simple_dual_port_ram.sv
// simple_dual_port_ram
//   Simple dual-port synchronous RAM, DEPTH = 2**ADDR_WIDTH words.
//   Ports:
//     clk  : single clock, rising edge
//     rst  : synchronous active-high reset (clears only the read output)
//     ifp  : sdpram_if.ram bundle
//            wena/addra/dina   - write port A
//            renb/addrb        - read port B
//            doutb/doutb_valid - registered read data, one-cycle latency
//   Same-address read and write on one edge is read-first.
module simple_dual_port_ram
  import sdpram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic   clk,
  input  logic   rst,
  sdpram_if.ram  ifp
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] doutb_q;
  logic                  doutb_valid_q;

  // NOTE: the array has no reset branch on purpose; a reset on memory
  // contents prevents block-RAM inference. Reset only gates the write.
  always_ff @(posedge clk) begin
    if (!rst && ifp.wena) begin
      // NOTE: non-blocking here is what makes a same-edge read see the old
      // word (read-first) regardless of block ordering.
      mem[ifp.addra] <= ifp.dina;
    end
  end

  // Output register: the only driver of doutb, so there is no
  // combinational path from addrb to doutb.
  always_ff @(posedge clk) begin
    if (rst) begin
      doutb_q       <= '0;
      doutb_valid_q <= 1'b0;
    end else begin
      doutb_valid_q <= ifp.renb;
      if (ifp.renb) begin
        doutb_q <= mem[ifp.addrb];
      end
    end
  end

  assign ifp.doutb       = doutb_q;
  assign ifp.doutb_valid = doutb_valid_q;

endmodule : simple_dual_port_ram

// File: tb/tb_simple_dual_port_ram.sv
// tb_simple_dual_port_ram
//   Directed bench for simple_dual_port_ram with a word-level reference
//   model (associative array of written words) checked every cycle, plus
//   literal expectations on the directed sequence.
module tb_simple_dual_port_ram;
  import sdpram_pkg::*;

  localparam int DW = DEFAULT_DATA_WIDTH;
  localparam int AW = DEFAULT_ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst;

  sdpram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  simple_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .ifp (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory is a map of written words; a read of an unwritten word makes
  // the expected data unknown, so only valid is compared then.
  data_t model_mem [int];
  data_t exp_dout;
  logic  exp_valid;
  logic  exp_known;
  logic  model_ready = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_dout    = '0;
      exp_valid   = 1'b0;
      exp_known   = 1'b1;
      model_ready = 1'b1;
    end else begin
      exp_valid = bus.renb;
      if (bus.renb) begin
        if (model_mem.exists(int'(bus.addrb))) begin
          exp_dout  = model_mem[int'(bus.addrb)];
          exp_known = 1'b1;
        end else begin
          exp_known = 1'b0;
        end
      end
      // Write applied after the read: read-first on address collision.
      if (bus.wena) model_mem[int'(bus.addra)] = bus.dina;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("cmp_valid", {{(DW-1){1'b0}}, bus.doutb_valid}, {{(DW-1){1'b0}}, exp_valid});
      if (exp_known) check("cmp_dout", bus.doutb, exp_dout);
    end
  end

  // ---------------- stimulus ----------------
  // Present one cycle's inputs just after a falling edge, then wait for the
  // next falling edge so the outputs of that rising edge are settled.
  task automatic step(input logic r, input logic w, input int wa,
                      input logic [DW-1:0] wd, input logic rd, input int ra);
    rst       = r;
    bus.wena  = w;
    bus.addra = addr_t'(wa);
    bus.dina  = wd;
    bus.renb  = rd;
    bus.addrb = addr_t'(ra);
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [DW-1:0] d,
                            input logic v);
    check({name, "_dout"}, bus.doutb, d);
    check({name, "_valid"}, {{(DW-1){1'b0}}, bus.doutb_valid}, {{(DW-1){1'b0}}, v});
  endtask

  initial begin
    rst       = 1'b1;
    bus.wena  = 1'b0;
    bus.addra = '0;
    bus.dina  = '0;
    bus.renb  = 1'b0;
    bus.addrb = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 3);
    expect_out("reset_state", 32'd0, 1'b0);

    // Basic writes and back-to-back reads
    step(0, 1, 5, 32'd350, 0, 0);
    step(0, 1, 7, 32'd670, 0, 0);
    step(0, 0, 0, 0, 1, 5);
    expect_out("read5", 32'd350, 1'b1);
    step(0, 0, 0, 0, 1, 7);
    expect_out("read7", 32'd670, 1'b1);
    step(0, 0, 0, 0, 0, 5);
    expect_out("hold", 32'd670, 1'b0);

    // Read-first collision, then new data visible
    step(0, 1, 5, 32'd961, 1, 5);
    expect_out("rdw_old", 32'd350, 1'b1);
    step(0, 0, 0, 0, 1, 5);
    expect_out("rdw_new", 32'd961, 1'b1);
    step(0, 0, 0, 0, 1, 5);
    expect_out("rdw_new2", 32'd961, 1'b1);

    // Reset mid-stream drops the read; a write during reset is ignored
    step(1, 1, 7, 32'd123, 1, 7);
    expect_out("rst_mid", 32'd0, 1'b0);
    step(0, 0, 0, 0, 1, 7);
    expect_out("mem_kept", 32'd670, 1'b1);

    // Address extremes, no aliasing
    step(0, 1, 0, 32'hFFFF_FFFF, 0, 0);
    step(0, 1, 1023, 32'h0000_0001, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    expect_out("addr0", 32'hFFFF_FFFF, 1'b1);
    step(0, 0, 0, 0, 1, 1023);
    expect_out("addr1023", 32'h0000_0001, 1'b1);

    // Independent ports on different addresses
    step(0, 1, 20, 32'hA5A5_A5A5, 0, 0);
    step(0, 1, 10, 32'hDEAD_BEEF, 1, 20);
    expect_out("indep_rd20", 32'hA5A5_A5A5, 1'b1);
    step(0, 0, 0, 0, 1, 10);
    expect_out("indep_rd10", 32'hDEAD_BEEF, 1'b1);
    step(0, 0, 0, 0, 1, 1023);
    expect_out("recheck1023", 32'h0000_0001, 1'b1);
    step(0, 0, 0, 0, 0, 0);
    expect_out("idle", 32'h0000_0001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_simple_dual_port_ram
